pc_fetch_sequencer: RTL and testbench

//  Drives the PC register's load side: computes next PC, asserts load, fetches the instruction at the current PC.

---
 rtl/mips_fetch_pkg.sv | 18 +
 rtl/fetch_hold_reg.sv | 51 +++++
 rtl/pc_fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Fetch sequencer shared definitions: FSM state encoding,
// default reset PC and sequential PC increment.
package mips_fetch_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_INC      = 4;

  typedef enum logic [1:0] {
    BOOT = ST_BOOT,
    REQ  = ST_REQ,
    HOLD = ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_reg.sv
// Output register for the fetched instruction toward decode.
// Ports: clk, rst (sync active-low), load/clear strobes,
// d_instr/d_pc data in, instr/instr_pc/instr_valid out.
module fetch_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_instr,
  input  logic [W-1:0] d_pc,
  output logic [W-1:0] instr,
  output logic [W-1:0] instr_pc,
  output logic         instr_valid
);

  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = d_instr;
      pc_d    = d_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: drives the PC register load side, runs the imem
// req/ack handshake and hands instructions to decode (valid/ready).
// Ports: pc_cur in; pc_next/pc_load out; imem_req/addr out,
// imem_ack/rdata in; instr/instr_pc/instr_valid out, instr_ready in;
// redirect/redirect_pc in. Sync active-low rst.
module pc_fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter int          B        = 32,
  parameter logic [B-1:0] RESET_PC = B'(DEF_RESET_PC),
  parameter int          INC      = DEF_INC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [B-1:0] pc_cur,
  output logic [B-1:0] pc_next,
  output logic         pc_load,
  output logic         imem_req,
  output logic [B-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [B-1:0] imem_rdata,
  output logic [B-1:0] instr,
  output logic [B-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [B-1:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic [B-1:0] addr_q, addr_d;
  logic         h_load, h_clr;
  logic         go_req;

  // HOLD with instr_valid=0 is the one-cycle gap after a
  // discarded ack; it always falls through to REQ.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    pc_load = 1'b0;
    pc_next = pc_cur + B'(INC);
    h_load  = 1'b0;
    h_clr   = 1'b0;
    go_req  = 1'b0;
    if (!rst) begin
      pc_next = '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          pc_load = 1'b1;
          pc_next = redirect ? redirect_pc : RESET_PC;
          go_req  = 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            kill_d  = 1'b0;
            state_d = HOLD;
            if (redirect) begin
              pc_load = 1'b1;
              pc_next = redirect_pc;
            end else if (!kill_q) begin
              pc_load = 1'b1;
              h_load  = 1'b1;
            end
          end else if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_pc;
            kill_d  = 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_pc;
            h_clr   = 1'b1;
            go_req  = 1'b1;
          end else if (!instr_valid || instr_ready) begin
            h_clr  = 1'b1;
            go_req = 1'b1;
          end
        end
        default: state_d = BOOT;
      endcase
      if (go_req) begin
        state_d = REQ;
        addr_d  = pc_load ? pc_next : pc_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      kill_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = addr_q;

  fetch_hold_reg #(
    .W(B)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (h_load),
    .clear      (h_clr),
    .d_instr    (imem_rdata),
    .d_pc       (addr_q),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid)
  );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a PC register model.
// Per-cycle vector table plus a zero-wait streaming sequence.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur = 32'hDEAD_0000;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (pc_load) pc_cur <= pc_next;

  pc_fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .pc_next    (pc_next),
    .pc_load    (pc_load),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        rst, ack;
    logic [31:0] rdata;
    logic        rdy, rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        ld;
    logic [31:0] nxt;
    logic        v, ck;
    logic [31:0] ins, ipc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rs, ak, input logic [31:0] rda,
    input logic ry, rr, input logic [31:0] rp,
    input logic rq, input logic [31:0] ad,
    input logic l, input logic [31:0] nx,
    input logic vv, c, input logic [31:0] in, ip);
    vec_t t;
    t.rst = rs; t.ack = ak; t.rdata = rda;
    t.rdy = ry; t.rd = rr; t.rpc = rp;
    t.req = rq; t.addr = ad; t.ld = l; t.nxt = nx;
    t.v = vv; t.ck = c; t.ins = in; t.ipc = ip;
    return t;
  endfunction

  task automatic fill();
    // rst ack rdata rdy rd rpc | req addr ld nxt v ck ins ipc
    tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 0,1,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 0,0,1,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,'hA0,0,0,0, 1,0,1,4, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1,0,'hA0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,0,0,0, 1,0,'hA0,0));
    tv.push_back(mk(1,1,'hA4,0,0,0, 1,4,1,8, 0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,4,0,0, 1,0,'hA4,4));
    tv.push_back(mk(1,1,'hA8,0,0,0, 1,8,1,'hC, 0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,8,0,0, 1,0,'hA8,8));
    tv.push_back(mk(1,1,'hAC,1,0,0, 1,'hC,1,'h10, 0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,'hC,0,0, 1,0,'hAC,'hC));
    tv.push_back(mk(1,1,'hB0,0,0,0, 1,'h10,1,'h14, 0,0,0,0));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(1,0,0,0,0,0, 0,'h10,0,0, 1,0,'hB0,'h10));
    tv.push_back(mk(1,0,0,1,0,0, 0,'h10,0,0, 1,0,'hB0,'h10));
    tv.push_back(mk(1,0,0,0,0,0, 1,'h14,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,1,'h100, 1,'h14,1,'h100, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 1,'h14,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 1,'h14,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,'hDEAD,1,0,0, 1,'h14,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,'h14,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,'hC100,0,0,0, 1,'h100,1,'h104, 0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,'h100,0,0, 1,0,'hC100,'h100));
    tv.push_back(mk(1,1,'hBAD,1,1,'h40, 1,'h104,1,'h40, 0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,'h104,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,'hC040,0,0,0, 1,'h40,1,'h44, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,1,'hFFFF_FFFC, 0,'h40,1,'hFFFF_FFFC,
                    1,0,'hC040,'h40));
    tv.push_back(mk(1,1,'hCFFC,0,0,0, 1,'hFFFF_FFFC,1,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,0, 0,'hFFFF_FFFC,0,0,
                    1,0,'hCFFC,'hFFFF_FFFC));
    tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,1,'h500, 1,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,'hEEEE,0,0,0, 0,0,1,0, 0,1,0,0));
    tv.push_back(mk(1,1,'hD000,0,0,0, 1,0,1,4, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1,0,'hD000,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1,0,'hD000,0));
    tv.push_back(mk(1,0,0,0,1,'h200, 0,0,1,'h200, 0,1,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 1,'h200,0,0, 0,0,0,0));
  endtask

  task automatic check_vec(input int idx, input vec_t t);
    bit ok;
    ok = (imem_req === t.req) && (imem_addr === t.addr) &&
         (pc_load === t.ld) && (instr_valid === t.v);
    if (t.ld || !t.rst) ok &= (pc_next === t.nxt);
    if (t.v || t.ck)
      ok &= (instr === t.ins) && (instr_pc === t.ipc);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL vec%0d: got req=%0b addr=%h ld=%0b nxt=%h v=%0b ins=%h ipc=%h want req=%0b addr=%h ld=%0b nxt=%h v=%0b ins=%h ipc=%h",
               idx, imem_req, imem_addr, pc_load, pc_next,
               instr_valid, instr, instr_pc, t.req, t.addr, t.ld,
               t.nxt, t.v, t.ins, t.ipc);
    end
  endtask

  initial begin
    logic [31:0] a;
    fill();
    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(posedge clk);
      #1;
      rst         = tv[i].rst;
      imem_ack    = tv[i].ack;
      imem_rdata  = tv[i].rdata;
      instr_ready = tv[i].rdy;
      redirect    = tv[i].rd;
      redirect_pc = tv[i].rpc;
      @(negedge clk);
      check_vec(i, tv[i]);
    end

    // zero-wait memory, decode always ready: PC 0x200 upward
    for (int n = 0; n < 6; n++) begin
      a = 32'h200 + 32'(4 * n);
      @(posedge clk);
      #1;
      imem_ack    = 1'b1;
      imem_rdata  = ~a;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      @(negedge clk);
      checks++;
      if (!(imem_req === 1'b1 && imem_addr === a &&
            pc_load === 1'b1 && pc_next === a + 32'd4)) begin
        failures++;
        $display("FAIL stream_req%0d: got req=%0b addr=%h ld=%0b nxt=%h want req=1 addr=%h ld=1 nxt=%h",
                 n, imem_req, imem_addr, pc_load, pc_next, a, a + 32'd4);
      end
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (!(instr_valid === 1'b1 && instr === ~a &&
            instr_pc === a && imem_req === 1'b0)) begin
        failures++;
        $display("FAIL stream_out%0d: got v=%0b ins=%h ipc=%h req=%0b want v=1 ins=%h ipc=%h req=0",
                 n, instr_valid, instr, instr_pc, imem_req, ~a, a);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
